// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory request port between NREQ requesters,
// with an order FIFO that routes in-order responses back to the issuing requester.
module mem_port_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DLEN   = 32,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*DLEN-1:0] i_req_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DLEN-1:0]      o_data,
  input  logic                 i_rsp_valid,
  output logic                 o_rsp_ready,
  input  logic [DLEN-1:0]      i_rsp_data,
  output logic [NREQ-1:0]      o_rsp_valid,
  input  logic [NREQ-1:0]      i_rsp_ready,
  output logic [DLEN-1:0]      o_rsp_data
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0]   rr_ptr, rr_next;
  logic            locked, locked_next;
  logic [IW-1:0]   lock_idx, lock_idx_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [IW-1:0]   fifo [MAXOUT];

  logic [IW-1:0]   grant, head;
  logic            any_valid, has_grant, full, empty, push, pop;
  logic [DLEN-1:0] grant_data;

  // Grant: locked requester wins, else first valid requester starting at rr_ptr
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_valid && i_req_valid[IW'(idx)]) begin
        any_valid = 1'b1;
        grant     = IW'(idx);
      end
    end
    if (locked) grant = lock_idx;
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == grant) grant_data = i_req_data[k*DLEN +: DLEN];
    end
  end

  assign full      = (count == CW'(MAXOUT));
  assign empty     = (count == '0);
  assign has_grant = locked | any_valid;
  assign head      = fifo[rd_ptr];

  // Request and response paths are pure pass-through, forced quiet during reset
  always_comb begin
    o_valid     = ~rst & has_grant & i_req_valid[grant] & ~full;
    o_data      = (~rst & has_grant) ? grant_data : '0;
    o_req_ready = '0;
    o_rsp_valid = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      o_req_ready[k] = ~rst & has_grant & (grant == IW'(k)) & i_ready & ~full;
      o_rsp_valid[k] = ~rst & i_rsp_valid & ~empty & (head == IW'(k));
    end
    o_rsp_ready = ~rst & ~empty & i_rsp_ready[head];
    o_rsp_data  = i_rsp_data;
  end

  assign push = o_valid & i_ready;
  assign pop  = o_rsp_ready & i_rsp_valid;

  // Lock holds the grant while downstream stalls; a dropped valid releases it
  always_comb begin
    locked_next   = locked;
    lock_idx_next = lock_idx;
    rr_next       = rr_ptr;
    if (push) begin
      locked_next = 1'b0;
      rr_next     = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
    end else if (o_valid && !i_ready) begin
      locked_next   = 1'b1;
      lock_idx_next = grant;
    end else if (locked && !i_req_valid[lock_idx]) begin
      locked_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      rr_ptr   <= rr_next;
      locked   <= locked_next;
      lock_idx <= lock_idx_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= grant;
  end

endmodule
